ram_fifo_1r1w_ctrl: RTL and testbench
=====================================

Name: ram_fifo_1r1w_ctrl

Overview:
- FIFO controller that drives an external 1R1W RAM through its rd_en/rd_add/rd_data and wr_en/wr_add/wr_data ports, and exposes valid/ready push and pop streams.
- Hides the RAM read latency with a small prefetch output buffer, so full-rate streaming (one word per cycle) is sustained.
- Connects directly to any 1R1W RAM wrapper instance.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 512, RAM depth in words; need not be a power of 2; must be >= 2.
- RAM_LATENCY, 1, RAM read latency in cycles; must be >= 1.
- Derived, not overridable: OBUF_DEPTH = RAM_LATENCY+1 register entries; AW = $clog2(DEPTH); LW = $clog2(DEPTH+OBUF_DEPTH+1).

Ports:
- clk  in  1  clock
- a_rst  in  1  asynchronous reset, active-high
- in_data  in  WIDTH  push data
- in_vld  in  1  push valid
- in_rdy  out  1  push ready
- out_data  out  WIDTH  pop data, head of FIFO
- out_vld  out  1  pop valid
- out_rdy  in  1  pop ready
- ram_rd_en  out  1  RAM read enable
- ram_rd_add  out  AW  RAM read address
- ram_rd_data  in  WIDTH  RAM read data, valid RAM_LATENCY cycles after ram_rd_en
- ram_wr_en  out  1  RAM write enable
- ram_wr_add  out  AW  RAM write address
- ram_wr_data  out  WIDTH  RAM write data
- level  out  LW  occupancy; see Optional Feature

Behaviour:
- One clock (clk). Reset a_rst is asynchronous and active-high. All state is cleared on a_rst assertion.
- Reset values: in_rdy=0 while a_rst is high. out_vld=0, ram_rd_en=0, ram_wr_en=0, level=0. Pointers and counters are 0. out_data is don't-care.
- Push:
  - push = in_vld & in_rdy.
  - ram_wr_en = push, combinational.
  - ram_wr_add = wp, ram_wr_data = in_data.
  - wp increments on push and wraps from DEPTH-1 to 0.
- Counters (registered):
  - ram_avail = words written but not yet read-issued.
  - ram_used = words written whose read data has not yet returned.
  - inflight = shift register of RAM_LATENCY valid bits.
  - obuf_cnt = 0..OBUF_DEPTH.
- in_rdy = (ram_used < DEPTH), from registered state only. There is no combinational path from out_rdy or ram_rd_data to in_rdy.
- Read issue:
  - Condition: ram_rd_en = (ram_avail > 0) & (popcount(inflight) + obuf_cnt - pop < OBUF_DEPTH), where pop = out_vld & out_rdy.
  - ram_rd_add = rp; rp increments on issue and wraps DEPTH-1 to 0.
- No same-address conflict:
  - A word written in cycle t is counted in ram_avail only from t+1, so the same address is never read and written in the same cycle.
  - Correct for every RAM read/write access type.
- Return: when the tail inflight bit is set, ram_rd_data is captured into the obuf at the end of that cycle, and ram_used decrements.
- Pop:
  - out_vld = (obuf_cnt > 0); out_data = obuf head, registered.
  - out_data is held stable while out_vld & !out_rdy.
  - Capture and pop in the same cycle are both applied, so obuf_cnt is unchanged.
- Latency: a word pushed in cycle t into an empty FIFO gives out_vld in cycle t+RAM_LATENCY+2.
- Throughput: with in_vld=out_rdy=1 continuously, one word per cycle in steady state.
- Capacity: DEPTH + OBUF_DEPTH words total. in_rdy drops when ram_used == DEPTH. A slot freed in cycle t is reusable from t+1.
- Ordering: strict FIFO, no loss, no duplication.
- Reset mid-operation: in-flight reads are discarded (inflight bits cleared), so returning RAM data is never presented. RAM contents are not cleared.

Optional Feature:
- Macro: RAM_FIFO_CTRL_LEVEL_EN.
- Defined: level = ram_used + obuf_cnt, registered, updated every cycle.
- Undefined: level tied to 0 and no level logic is built.

Test Plan:
1. Latency. WIDTH=32, DEPTH=8, RAM_LATENCY=2, out_rdy=1, single push 0xA5 at cycle 0 after reset -> out_vld=1 with out_data=0xA5 first in cycle 4; ram_rd_en pulses once in cycle 1.
2. Capacity. out_rdy=0, in_vld=1 pushing 0,1,2,... -> exactly 11 words (0..10) accepted, then in_rdy=0. Afterwards out_rdy=1 pops 0..10 in order. ram_rd_add never equals ram_wr_add while both enables are 1.
3. Wrap-around. Stream 100 incrementing words with in_vld=out_rdy=1 -> after the initial 4-cycle latency, one word per cycle, in order; wp/rp wrap 7->0 repeatedly without a bubble.
4. Backpressure. Random out_rdy (50%) with random in_vld, 1000 words -> output equals input sequence; out_data stable whenever out_vld & !out_rdy.
5. Reset mid-operation. Assert a_rst for 1 cycle while 2 reads are in flight -> out_vld=0, level=0, no stale word emitted. Next push 0x3C is the first word out.
6. Level (RAM_FIFO_CTRL_LEVEL_EN defined). out_rdy=0, push 5 words -> level=5; pop 2 -> level=3. Without the macro, level=0 throughout.

Source files
------------

// File: rtl/ram_fifo_1r1w_ctrl.sv
// FIFO controller for an external 1R1W RAM, with a prefetch output buffer that hides RAM read latency.
// Optional occupancy output is built only when RAM_FIFO_CTRL_LEVEL_EN is defined; otherwise level is tied to 0.
module ram_fifo_1r1w_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 512,
  parameter int RAM_LATENCY = 1,
  localparam int OBUF_DEPTH = RAM_LATENCY + 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = $clog2(DEPTH + OBUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_rd_add,
  input  logic [WIDTH-1:0] ram_rd_data,
  output logic             ram_wr_en,
  output logic [AW-1:0]    ram_wr_add,
  output logic [WIDTH-1:0] ram_wr_data,
  output logic [LW-1:0]    level
);

  localparam int OW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = $clog2(OBUF_DEPTH);

  logic                   push, pop, issue, ret;
  logic [AW-1:0]          wp, rp;
  logic [LW-1:0]          ram_avail, ram_used;
  logic [LW-1:0]          avail_nxt, used_nxt;
  logic [RAM_LATENCY-1:0] inflight;
  logic [OW-1:0]          obuf_cnt, obuf_nxt;
  logic [PW-1:0]          hd, tl;
  logic [LW-1:0]          fill;
  logic [WIDTH-1:0]       obuf [OBUF_DEPTH];

  // in_rdy looks only at registered occupancy, so the push side never waits on out_rdy.
  assign in_rdy  = !a_rst && (ram_used < LW'(DEPTH));
  assign push    = in_vld && in_rdy;
  assign out_vld = (obuf_cnt != '0);
  assign pop     = out_vld && out_rdy;
  assign ret     = inflight[RAM_LATENCY-1];

  assign ram_wr_en   = push;
  assign ram_wr_add  = wp;
  assign ram_wr_data = in_data;

  // Words already promised to the output buffer: reads in flight plus buffered words.
  always_comb begin
    fill = LW'(obuf_cnt);
    for (int i = 0; i < RAM_LATENCY; i++) fill = fill + LW'(inflight[i]);
  end

  // ram_avail only counts a word the cycle after its write, so a read never hits a same-cycle write.
  assign issue      = (ram_avail != '0) && (fill < LW'(OBUF_DEPTH) + LW'(pop));
  assign ram_rd_en  = issue;
  assign ram_rd_add = rp;
  assign out_data   = obuf[hd];

  assign avail_nxt = ram_avail + LW'(push) - LW'(issue);
  assign used_nxt  = ram_used + LW'(push) - LW'(ret);
  assign obuf_nxt  = obuf_cnt + OW'(ret) - OW'(pop);

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wp        <= '0;
      rp        <= '0;
      ram_avail <= '0;
      ram_used  <= '0;
      inflight  <= '0;
      obuf_cnt  <= '0;
      hd        <= '0;
      tl        <= '0;
    end else begin
      if (push)  wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      if (issue) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
      if (ret)   tl <= (tl == PW'(OBUF_DEPTH - 1)) ? '0 : tl + PW'(1);
      if (pop)   hd <= (hd == PW'(OBUF_DEPTH - 1)) ? '0 : hd + PW'(1);
      ram_avail <= avail_nxt;
      ram_used  <= used_nxt;
      obuf_cnt  <= obuf_nxt;
      inflight[0] <= issue;
      for (int i = 1; i < RAM_LATENCY; i++) inflight[i] <= inflight[i-1];
    end
  end

  // Buffer storage needs no reset: an entry is only visible after a tracked capture.
  always_ff @(posedge clk) begin
    if (ret) obuf[tl] <= ram_rd_data;
  end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
  logic [LW-1:0] level_q;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) level_q <= '0;
    else       level_q <= used_nxt + LW'(obuf_nxt);
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_ram_fifo_1r1w_ctrl.sv
// Directed bench for ram_fifo_1r1w_ctrl with a 2-cycle-latency behavioural RAM.
module tb_ram_fifo_1r1w_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int RAM_LATENCY = 2;
  localparam int AW = 3;
  localparam int LW = 4;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic a_rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic in_vld = 1'b0;
  logic in_rdy;
  logic [WIDTH-1:0] out_data;
  logic out_vld;
  logic out_rdy = 1'b0;
  logic ram_rd_en;
  logic [AW-1:0] ram_rd_add;
  logic [WIDTH-1:0] ram_rd_data;
  logic ram_wr_en;
  logic [AW-1:0] ram_wr_add;
  logic [WIDTH-1:0] ram_wr_data;
  logic [LW-1:0] level;

  int n_chk = 0;
  int n_fail = 0;

  ram_fifo_1r1w_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RAM_LATENCY(RAM_LATENCY)) dut (
    .clk(clk), .a_rst(a_rst),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .ram_rd_en(ram_rd_en), .ram_rd_add(ram_rd_add), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_add(ram_wr_add), .ram_wr_data(ram_wr_data),
    .level(level)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: data for a read issued in cycle t is on ram_rd_data during cycle t+2.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] s1, s2;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_add] <= ram_wr_data;
    s1 <= mem[ram_rd_add];
    s2 <= s1;
  end
  assign ram_rd_data = s2;

  task automatic do_reset();
    a_rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; in_vld = 1'b1; out_rdy = 1'b1; in_data = 32'hDEAD;
    @(negedge clk);
    n_chk++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy got %b want 0", in_rdy); end
    n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld got %b want 0", out_vld); end
    n_chk++; if (ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b want 0", ram_wr_en); end
    n_chk++; if (ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got %b want 0", ram_rd_en); end
    n_chk++; if (level !== '0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
    do_reset();
    @(negedge clk);
    n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_rdy got %b want 1", in_rdy); end
  endtask

  task automatic test_latency();
    int first_vld, rd_cnt, rd_at, vld_cnt;
    logic [WIDTH-1:0] first_data;
    first_vld = -1; rd_cnt = 0; rd_at = -1; vld_cnt = 0; first_data = '0;
    do_reset();
    in_vld = 1'b1; in_data = 32'hA5; out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL lat_push got in_rdy %b want 1", in_rdy); end
      end
      if (ram_rd_en) begin rd_cnt++; rd_at = k; end
      if (out_vld) begin
        vld_cnt++;
        if (first_vld < 0) begin first_vld = k; first_data = out_data; end
      end
      @(posedge clk); #1 in_vld = 1'b0;
    end
    n_chk++; if (first_vld != 4) begin n_fail++; $display("FAIL lat_cycle got %0d want 4", first_vld); end
    n_chk++; if (first_data !== 32'hA5) begin n_fail++; $display("FAIL lat_data got %h want a5", first_data); end
    n_chk++; if (rd_cnt != 1 || rd_at != 1) begin n_fail++; $display("FAIL lat_rd_en got %0d pulses last at %0d want 1 at 1", rd_cnt, rd_at); end
    n_chk++; if (vld_cnt != 1) begin n_fail++; $display("FAIL lat_vld_cnt got %0d want 1", vld_cnt); end
  endtask

  task automatic test_capacity();
    int cnt, conflict, popped;
    cnt = 0; conflict = 0; popped = 0;
    do_reset();
    in_vld = 1'b1; in_data = 0; out_rdy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ram_rd_en && ram_wr_en && ram_rd_add == ram_wr_add) conflict++;
      if (in_vld && in_rdy) cnt++;
      @(posedge clk); #1 in_data = cnt;
    end
    in_vld = 1'b0;
    @(negedge clk);
    n_chk++; if (cnt != 11) begin n_fail++; $display("FAIL cap_count got %0d want 11", cnt); end
    n_chk++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL cap_in_rdy got %b want 0", in_rdy); end
    n_chk++; if (level !== (LVL ? LW'(11) : LW'(0))) begin n_fail++; $display("FAIL cap_level got %0d want %0d", level, LVL ? 11 : 0); end
    @(posedge clk); #1 out_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ram_rd_en && ram_wr_en && ram_rd_add == ram_wr_add) conflict++;
      if (out_vld) begin
        n_chk++;
        if (out_data !== WIDTH'(popped)) begin n_fail++; $display("FAIL cap_order got %0d want %0d", out_data, popped); end
        popped++;
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b0;
    n_chk++; if (popped != 11) begin n_fail++; $display("FAIL cap_popped got %0d want 11", popped); end
    n_chk++; if (conflict != 0) begin n_fail++; $display("FAIL cap_addr_conflict got %0d want 0", conflict); end
  endtask

  task automatic test_back_to_back();
    int pushed, popped, first, bubbles, conflict;
    pushed = 0; popped = 0; first = -1; bubbles = 0; conflict = 0;
    do_reset();
    in_vld = 1'b1; in_data = 0; out_rdy = 1'b1;
    for (int k = 0; k < 200 && popped < 100; k++) begin
      @(negedge clk);
      if (ram_rd_en && ram_wr_en && ram_rd_add == ram_wr_add) conflict++;
      if (in_vld && in_rdy) pushed++;
      if (out_vld) begin
        n_chk++;
        if (out_data !== WIDTH'(popped)) begin n_fail++; $display("FAIL stream_order got %0d want %0d", out_data, popped); end
        if (first < 0) first = k;
        popped++;
      end else if (first >= 0) bubbles++;
      @(posedge clk); #1;
      if (pushed >= 100) in_vld = 1'b0;
      in_data = pushed;
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    n_chk++; if (first != 4) begin n_fail++; $display("FAIL stream_first got %0d want 4", first); end
    n_chk++; if (bubbles != 0) begin n_fail++; $display("FAIL stream_bubbles got %0d want 0", bubbles); end
    n_chk++; if (popped != 100) begin n_fail++; $display("FAIL stream_popped got %0d want 100", popped); end
    n_chk++; if (conflict != 0) begin n_fail++; $display("FAIL stream_addr_conflict got %0d want 0", conflict); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp, hold_d;
    logic hold_v;
    int pushed, popped;
    pushed = 0; popped = 0; hold_v = 1'b0; hold_d = '0;
    do_reset();
    in_vld = 1'($urandom % 2); in_data = $urandom; out_rdy = 1'($urandom % 2);
    for (int k = 0; k < 20000 && popped < 1000; k++) begin
      @(negedge clk);
      if (hold_v) begin
        n_chk++;
        if (out_vld !== 1'b1 || out_data !== hold_d) begin
          n_fail++; $display("FAIL bp_stable got vld %b data %h want vld 1 data %h", out_vld, out_data, hold_d);
        end
      end
      if (in_vld && in_rdy) begin sb.push_back(in_data); pushed++; end
      if (out_vld && out_rdy) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_chk++;
        if (out_data !== exp) begin n_fail++; $display("FAIL bp_order got %h want %h", out_data, exp); end
        popped++;
      end
      hold_v = out_vld && !out_rdy;
      hold_d = out_data;
      @(posedge clk); #1;
      in_vld  = (pushed < 1000) && 1'($urandom % 2);
      in_data = $urandom;
      out_rdy = 1'($urandom % 2);
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    n_chk++; if (popped != 1000) begin n_fail++; $display("FAIL bp_popped got %0d want 1000", popped); end
  endtask

  task automatic test_reset_midop();
    int rd_cnt, stale, outs;
    logic [WIDTH-1:0] first_data;
    rd_cnt = 0; stale = 0; outs = 0; first_data = '0;
    do_reset();
    out_rdy = 1'b0; in_vld = 1'b1; in_data = 32'h11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ram_rd_en) rd_cnt++;
      @(posedge clk); #1;
      if (k == 0) in_data = 32'h22; else in_vld = 1'b0;
    end
    n_chk++; if (rd_cnt != 2) begin n_fail++; $display("FAIL mid_reads got %0d want 2", rd_cnt); end
    a_rst = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    n_chk++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got %b want 0", out_vld); end
    n_chk++; if (level !== '0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", level); end
    @(posedge clk); #1 a_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_vld) stale++;
      @(posedge clk); #1;
    end
    n_chk++; if (stale != 0) begin n_fail++; $display("FAIL mid_stale got %0d words want 0", stale); end
    n_chk++; if (level !== '0) begin n_fail++; $display("FAIL mid_level got %0d want 0", level); end
    in_vld = 1'b1; in_data = 32'h3C;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_vld) begin
        if (outs == 0) first_data = out_data;
        outs++;
      end
      @(posedge clk); #1 in_vld = 1'b0;
    end
    out_rdy = 1'b0;
    n_chk++; if (first_data !== 32'h3C) begin n_fail++; $display("FAIL mid_first got %h want 3c", first_data); end
    n_chk++; if (outs != 1) begin n_fail++; $display("FAIL mid_outs got %0d want 1", outs); end
  endtask

  task automatic test_level();
    do_reset();
    out_rdy = 1'b0; in_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = k;
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_chk++; if (level !== (LVL ? LW'(5) : LW'(0))) begin n_fail++; $display("FAIL lvl_5 got %0d want %0d", level, LVL ? 5 : 0); end
    @(posedge clk); #1 out_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if (out_vld !== 1'b1 || out_data !== WIDTH'(k)) begin
        n_fail++; $display("FAIL lvl_pop got vld %b data %0d want vld 1 data %0d", out_vld, out_data, k);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_chk++; if (level !== (LVL ? LW'(3) : LW'(0))) begin n_fail++; $display("FAIL lvl_3 got %0d want %0d", level, LVL ? 3 : 0); end
    n_chk++; if (out_vld !== 1'b1 || out_data !== 32'd2) begin n_fail++; $display("FAIL lvl_head got vld %b data %0d want vld 1 data 2", out_vld, out_data); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_capacity();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_level();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
